// File: rtl/spi_clk_scheduler_pkg.sv
// Shared types and helpers for the SPI clock scheduler: owner/state enums and
// the phase-counter width calculation.
package spi_clk_scheduler_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SCI  = 2'd1,
        OWN_SDI  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIG,
        S_GRANT,
        S_GAP
    } sched_state_e;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        return $clog2(max3(a, b, c)) + 1;
    endfunction

endpackage

// File: rtl/spi_clk_scheduler_if.sv
// Handshake and divider-control bundle between the SCI/SDI engines, the
// scheduler and the clock divider.
interface spi_clk_scheduler_if #(
    parameter int unsigned WIDTH = 32
);
    import spi_clk_scheduler_pkg::*;

    logic             sci_req;
    logic             sci_release;
    logic             sci_grant;
    logic             sdi_req;
    logic             sdi_release;
    logic             sdi_grant;
    logic             div_enable;
    logic [WIDTH-1:0] div_count;
    logic             busy;
    owner_e           owner;
    logic             timeout_err;
    logic             clear_err;

    modport master (
        output sci_req, sci_release, sdi_req, sdi_release, clear_err,
        input  sci_grant, sdi_grant, div_enable, div_count, busy, owner, timeout_err
    );

    modport slave (
        input  sci_req, sci_release, sdi_req, sdi_release, clear_err,
        output sci_grant, sdi_grant, div_enable, div_count, busy, owner, timeout_err
    );

endinterface

// File: rtl/spi_clk_scheduler_sched_timer.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
module sched_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_clk_scheduler.sv
// Round-robin owner of the shared SPI clock divider: configures it for the
// winning path, waits for it to settle, grants, then enforces an idle gap.
module spi_clk_scheduler
    import spi_clk_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SCI_DIV    = 24,
    parameter int unsigned SDI_DIV    = 3,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned GAP_CYC    = 4,
    parameter int unsigned HOLD_MAX   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_clk_scheduler_if.slave  bus
);

    localparam int unsigned     CNT_W     = cnt_width(SETTLE_CYC, GAP_CYC, HOLD_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic             WDOG_EN   = (HOLD_MAX != 0);
    localparam logic [WIDTH-1:0] SCI_CNT   = WIDTH'(SCI_DIV);
    localparam logic [WIDTH-1:0] SDI_CNT   = WIDTH'(SDI_DIV);

    sched_state_e     state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_owner_q, last_owner_d;
    owner_e           pick;
    logic             owner_req, owner_rel, set_err;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;

    logic             div_enable_q, div_enable_d;
    logic [WIDTH-1:0] div_count_q, div_count_d;
    logic             sci_grant_q, sci_grant_d;
    logic             sdi_grant_q, sdi_grant_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;

    assign owner_req = (owner_q == OWN_SCI) ? bus.sci_req : bus.sdi_req;
    assign owner_rel = (owner_q == OWN_SCI) ? bus.sci_release : bus.sdi_release;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        set_err      = 1'b0;
        pick         = OWN_NONE;
        unique case (state_q)
            S_IDLE: begin
                // On a tie, the path that did not own the divider last wins.
                if (bus.sci_req && bus.sdi_req) begin
                    pick = (last_owner_q == OWN_SCI) ? OWN_SDI : OWN_SCI;
                end else if (bus.sci_req) begin
                    pick = OWN_SCI;
                end else if (bus.sdi_req) begin
                    pick = OWN_SDI;
                end
                if (pick != OWN_NONE) begin
                    state_d = S_CONFIG;
                    owner_d = pick;
                end
            end
            S_CONFIG: begin
                if (!owner_req) begin
                    state_d = S_GAP;
                    owner_d = OWN_NONE;
                end else if (tmr_done) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // A release on the watchdog's final cycle takes priority.
                if (owner_rel || (WDOG_EN && tmr_done)) begin
                    state_d      = S_GAP;
                    owner_d      = OWN_NONE;
                    last_owner_d = owner_q;
                    set_err      = !owner_rel;
                end
            end
            S_GAP: begin
                if (tmr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_val = '0;
        unique case (state_d)
            S_CONFIG: tmr_val = SETTLE_LD;
            S_GRANT:  tmr_val = HOLD_LD;
            S_GAP:    tmr_val = GAP_LD;
            default:  tmr_val = '0;
        endcase
    end

    sched_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    always_comb begin
        div_enable_d  = (state_d == S_CONFIG) || (state_d == S_GRANT);
        sci_grant_d   = (state_d == S_GRANT) && (owner_d == OWN_SCI);
        sdi_grant_d   = (state_d == S_GRANT) && (owner_d == OWN_SDI);
        busy_d        = (state_d != S_IDLE);
        timeout_err_d = set_err || (timeout_err_q && !bus.clear_err);
        // Count is only reprogrammed while the divider is stopped.
        div_count_d   = div_count_q;
        if (state_d == S_IDLE) begin
            div_count_d = '0;
        end else if (state_q == S_IDLE && state_d == S_CONFIG) begin
            div_count_d = (owner_d == OWN_SCI) ? SCI_CNT : SDI_CNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_NONE;
            last_owner_q  <= OWN_SDI;
            div_enable_q  <= 1'b0;
            div_count_q   <= '0;
            sci_grant_q   <= 1'b0;
            sdi_grant_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            div_enable_q  <= div_enable_d;
            div_count_q   <= div_count_d;
            sci_grant_q   <= sci_grant_d;
            sdi_grant_q   <= sdi_grant_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.sci_grant   = sci_grant_q;
    assign bus.sdi_grant   = sdi_grant_q;
    assign bus.div_enable  = div_enable_q;
    assign bus.div_count   = div_count_q;
    assign bus.busy        = busy_q;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_clk_scheduler.sv
// Cycle-by-cycle vector bench for spi_clk_scheduler with HOLD_MAX=10.
module tb_spi_clk_scheduler;
    import spi_clk_scheduler_pkg::*;

    typedef enum int {K_IDLE, K_CFG_SCI, K_CFG_SDI, K_GNT_SCI, K_GNT_SDI, K_GAP} kind_e;

    // in = {sci_req, sci_release, sdi_req, sdi_release, clear_err}
    typedef struct {
        logic [4:0] in;
        kind_e      kind;
        logic       terr;
    } vec_t;

    // flags = {sci_grant, sdi_grant, div_enable, busy, owner[1:0], timeout_err}
    typedef struct {
        logic [6:0]  flags;
        logic [31:0] cnt;
        logic        chk_cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    spi_clk_scheduler_if #(.WIDTH(32)) bus ();

    spi_clk_scheduler #(
        .WIDTH     (32),
        .SCI_DIV   (24),
        .SDI_DIV   (3),
        .SETTLE_CYC(2),
        .GAP_CYC   (4),
        .HOLD_MAX  (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic exp_t model(kind_e k, logic terr);
        exp_t e;
        e.flags   = '0;
        e.cnt     = '0;
        e.chk_cnt = 1'b1;
        case (k)
            K_CFG_SCI: begin e.flags[4] = 1; e.flags[3] = 1; e.flags[2:1] = 2'd1; e.cnt = 24; end
            K_CFG_SDI: begin e.flags[4] = 1; e.flags[3] = 1; e.flags[2:1] = 2'd2; e.cnt = 3; end
            K_GNT_SCI: begin
                e.flags[6] = 1; e.flags[4] = 1; e.flags[3] = 1; e.flags[2:1] = 2'd1; e.cnt = 24;
            end
            K_GNT_SDI: begin
                e.flags[5] = 1; e.flags[4] = 1; e.flags[3] = 1; e.flags[2:1] = 2'd2; e.cnt = 3;
            end
            K_GAP:     begin e.flags[3] = 1; e.chk_cnt = 0; end
            default:   ;
        endcase
        e.flags[0] = terr;
        return e;
    endfunction

    task automatic check_now(input string name, input int idx, input exp_t e);
        logic [6:0] got;
        got = {bus.sci_grant, bus.sdi_grant, bus.div_enable, bus.busy, bus.owner,
               bus.timeout_err};
        total++;
        if (got !== e.flags) begin
            bad++;
            $display("FAIL %s[%0d] flags got=%b want=%b (sci_g sdi_g en busy owner terr)",
                     name, idx, got, e.flags);
        end
        if (e.chk_cnt) begin
            total++;
            if (bus.div_count !== e.cnt) begin
                bad++;
                $display("FAIL %s[%0d] div_count got=%0d want=%0d", name, idx, bus.div_count,
                         e.cnt);
            end
        end
    endtask

    task automatic add(input logic [4:0] in, input kind_e k, input logic terr, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{in, k, terr});
    endtask

    task automatic step(input string name, input int idx, input vec_t v);
        exp_t e;
        {bus.sci_req, bus.sci_release, bus.sdi_req, bus.sdi_release, bus.clear_err} = v.in;
        exp_q.push_back(model(v.kind, v.terr));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_now(name, idx, e);
    endtask

    initial begin
        {bus.sci_req, bus.sci_release, bus.sdi_req, bus.sdi_release, bus.clear_err} = '0;

        // Tie out of reset: SCI first, then SDI after the gap; stray releases ignored.
        add(5'b10100, K_CFG_SCI, 0, 2);
        add(5'b10100, K_GNT_SCI, 0, 2);
        add(5'b01100, K_GAP,     0, 1);
        add(5'b00100, K_GAP,     0, 3);
        add(5'b00100, K_IDLE,    0, 1);
        add(5'b00100, K_CFG_SDI, 0, 2);
        add(5'b00100, K_GNT_SDI, 0, 1);
        add(5'b01100, K_GNT_SDI, 0, 1);
        add(5'b00010, K_GAP,     0, 2);
        add(5'b00000, K_GAP,     0, 2);
        add(5'b00000, K_IDLE,    0, 2);
        // SDI request dropped mid-CONFIG.
        add(5'b00100, K_CFG_SDI, 0, 1);
        add(5'b00000, K_GAP,     0, 4);
        add(5'b00000, K_IDLE,    0, 1);
        // Watchdog revoke on the 10th grant cycle, sticky error, clear.
        add(5'b00100, K_CFG_SDI, 0, 2);
        add(5'b00100, K_GNT_SDI, 0, 1);
        add(5'b00000, K_GNT_SDI, 0, 9);
        add(5'b00000, K_GAP,     1, 4);
        add(5'b00000, K_IDLE,    1, 1);
        add(5'b00001, K_IDLE,    0, 1);
        // Release on the 10th grant cycle beats the watchdog.
        add(5'b00100, K_CFG_SDI, 0, 2);
        add(5'b00100, K_GNT_SDI, 0, 1);
        add(5'b00000, K_GNT_SDI, 0, 9);
        add(5'b00010, K_GAP,     0, 1);
        add(5'b00000, K_GAP,     0, 3);
        add(5'b00000, K_IDLE,    0, 1);
        // Leave last_owner=SCI, then hold SDI granted for the reset test.
        add(5'b10000, K_CFG_SCI, 0, 2);
        add(5'b10000, K_GNT_SCI, 0, 1);
        add(5'b01000, K_GAP,     0, 1);
        add(5'b00000, K_GAP,     0, 3);
        add(5'b00000, K_IDLE,    0, 1);
        add(5'b00100, K_CFG_SDI, 0, 2);
        add(5'b00100, K_GNT_SDI, 0, 2);

        #12;
        check_now("reset", 0, model(K_IDLE, 0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) step("vec", i, vecs[i]);

        // Asynchronous reset mid-grant with both requests high.
        {bus.sci_req, bus.sci_release, bus.sdi_req, bus.sdi_release, bus.clear_err} = 5'b10100;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst", 0, model(K_IDLE, 0));
        @(posedge clk);
        #1;
        check_now("rst_held", 0, model(K_IDLE, 0));
        #3;
        rst_n = 1'b1;
        step("post_rst", 0, '{5'b10100, K_CFG_SCI, 1'b0});
        step("post_rst", 1, '{5'b10100, K_CFG_SCI, 1'b0});
        step("post_rst", 2, '{5'b10100, K_GNT_SCI, 1'b0});
        step("post_rst", 3, '{5'b01100, K_GAP,     1'b0});
        for (int i = 0; i < 3; i++) step("post_rst_gap", i, '{5'b00100, K_GAP, 1'b0});
        step("post_rst", 4, '{5'b00100, K_IDLE,    1'b0});
        step("post_rst", 5, '{5'b00100, K_CFG_SDI, 1'b0});
        step("post_rst", 6, '{5'b00100, K_CFG_SDI, 1'b0});
        step("post_rst", 7, '{5'b00100, K_GNT_SDI, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
